// File: rtl/countdown_timer_if.sv
// Bundles the load handshake, run controls and timer status of countdown_timer.
// The master side (controller) drives loads and controls; the slave side (timer)
// returns count, busy, done and load_ready.
interface countdown_timer_if #(
    parameter int N = 4
) ();
    logic         load_valid;
    logic [N-1:0] load_value;
    logic         load_ready;
    logic         start;
    logic         pause;
    logic         stop;
    logic         tick_en;
    logic         auto_reload;
    logic [N-1:0] count;
    logic         busy;
    logic         done;

    modport master (
        output load_valid, load_value, start, pause, stop, tick_en, auto_reload,
        input  load_ready, count, busy, done
    );

    modport slave (
        input  load_valid, load_value, start, pause, stop, tick_en, auto_reload,
        output load_ready, count, busy, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable N-bit down-counting timer (N in 4..8).
// The count register feeds a saturating decrementor whose result is written back
// on every enabled tick while running. Reaching terminal count raises a one-cycle
// done pulse and either returns to idle or reloads the last loaded value.
// Per-cycle priority: rst > stop > load > pause > start > tick_en.
module countdown_timer #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   tif
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

    // Saturating decrement: zero stays zero so the count can never wrap to all-ones.
    function automatic logic [N-1:0] decrementor(input logic [N-1:0] value);
        logic [N-1:0] result;
        if (value == CNT_ZERO) begin
            result = CNT_ZERO;
        end else begin
            result = value - CNT_ONE;
        end
        return result;
    endfunction

    state_t       state_r;
    logic [N-1:0] count_r;
    logic [N-1:0] reload_r;
    logic         done_r;
    logic [N-1:0] dec_s;

    // Next value offered by the decrementor for the current count.
    always_comb begin
        dec_s = decrementor(count_r);
    end

    // Timer FSM: state, count, reload value and the registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            count_r  <= CNT_ZERO;
            reload_r <= CNT_ZERO;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (tif.stop) begin
                state_r <= ST_IDLE;
                count_r <= CNT_ZERO;
            end else if (tif.load_valid && (state_r != ST_RUN)) begin
                // Loads are accepted in IDLE and HOLD and always leave the timer idle.
                state_r  <= ST_IDLE;
                count_r  <= tif.load_value;
                reload_r <= tif.load_value;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        // A zero count cannot be started; it would give a spurious done.
                        if (tif.start && (count_r != CNT_ZERO)) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (tif.pause) begin
                            state_r <= ST_HOLD;
                        end else if (tif.tick_en) begin
                            if (count_r == CNT_ONE) begin
                                done_r <= 1'b1;
                                if (tif.auto_reload) begin
                                    count_r <= reload_r;
                                end else begin
                                    count_r <= CNT_ZERO;
                                    state_r <= ST_IDLE;
                                end
                            end else if (count_r == CNT_ZERO) begin
                                // Unreachable while running; recover to idle quietly.
                                state_r <= ST_IDLE;
                            end else begin
                                count_r <= dec_s;
                            end
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_HOLD: begin
                        if (tif.start && !tif.pause) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_HOLD;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        count_r <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    // Status outputs come straight from registers; no input reaches them combinationally.
    assign tif.count      = count_r;
    assign tif.done       = done_r;
    assign tif.busy       = (state_r == ST_RUN) || (state_r == ST_HOLD);
    assign tif.load_ready = (state_r != ST_RUN);
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus randomized control traffic.
// A stimulus process drives inputs on the falling edge, steps a behavioural
// model and queues the expected post-edge outputs; a monitor pops and compares
// after each rising edge.
module tb_countdown_timer;
    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] count;
        logic         busy;
        logic         done;
        logic         ready;
    } exp_t;

    logic clk;
    logic rst;

    countdown_timer_if #(.N(N)) tif ();

    countdown_timer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    // Behavioural model: plain integers and flags describing the timer.
    int m_count;
    int m_reload;
    bit m_busy;
    bit m_paused;
    bit m_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock cycle of stimulus; the model predicts what the timer shows afterwards.
    task automatic cyc(input logic r, input logic lv, input int val, input logic st,
                       input logic ps, input logic sp, input logic te, input logic ar);
        bit   counting;
        exp_t e;
        @(negedge clk);
        rst             = r;
        tif.load_valid  = lv;
        tif.load_value  = val[N-1:0];
        tif.start       = st;
        tif.pause       = ps;
        tif.stop        = sp;
        tif.tick_en     = te;
        tif.auto_reload = ar;

        counting = m_busy && !m_paused;
        if (r) begin
            m_count = 0; m_reload = 0; m_busy = 1'b0; m_paused = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (sp) begin
                m_count = 0; m_busy = 1'b0; m_paused = 1'b0;
            end else if (lv && !counting) begin
                m_count = val % (1 << N); m_reload = m_count;
                m_busy = 1'b0; m_paused = 1'b0;
            end else if (counting) begin
                if (ps) begin
                    m_paused = 1'b1;
                end else if (te) begin
                    if (m_count == 1) begin
                        m_done = 1'b1;
                        if (ar) begin
                            m_count = m_reload;
                        end else begin
                            m_count = 0;
                            m_busy  = 1'b0;
                        end
                    end else begin
                        m_count = m_count - 1;
                    end
                end
            end else if (m_busy) begin
                if (st && !ps) m_paused = 1'b0;
            end else begin
                if (st && m_count != 0) m_busy = 1'b1;
            end
        end
        e.count = m_count[N-1:0];
        e.busy  = m_busy;
        e.done  = m_done;
        e.ready = !(m_busy && !m_paused);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input int v);
        cyc(1'b0, 1'b1, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go();
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n, input logic ar);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, ar);
    endtask

    // Monitor: after every rising edge compare the oldest queued expectation.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.count = tif.count;
                a.busy  = tif.busy;
                a.done  = tif.done;
                a.ready = tif.load_ready;
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got count=%0d busy=%b done=%b ready=%b, want count=%0d busy=%b done=%b ready=%b",
                             $time, a.count, a.busy, a.done, a.ready,
                             e.count, e.busy, e.done, e.ready);
                end
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        bit ar_phase;
        bit lv, st, ps, sp, te, r;
        n_cmp = 0;
        n_bad = 0;
        m_count = 0; m_reload = 0; m_busy = 1'b0; m_paused = 1'b0; m_done = 1'b0;
        rst = 1'b1;
        tif.load_valid = 1'b0; tif.load_value = '0; tif.start = 1'b0; tif.pause = 1'b0;
        tif.stop = 1'b0; tif.tick_en = 1'b0; tif.auto_reload = 1'b0;

        // Reset values.
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Plain countdown 5..0 with done at zero.
        load(5); go(); ticks(7, 1'b0); idle(1);

        // Periodic auto-reload of 3, then stop.
        load(3); go(); ticks(10, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Reload value 1: done every tick.
        load(1); go(); ticks(4, 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Alternating tick_en.
        load(4); go();
        for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, (k % 2 == 0), 1'b0);

        // Pause at 4, hold, load_ready high, pause+start stays held, then resume.
        load(6); go(); ticks(2, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        go(); ticks(5, 1'b0);

        // Load 0 cannot start; load during RUN ignored.
        load(0); go(); go(); idle(1);
        load(7); go();
        cyc(1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(2, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Load while held returns to idle.
        load(9); go(); ticks(1, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        load(12); go(); ticks(3, 1'b0);

        // Max value, then reset mid-count.
        load(15); go(); ticks(4, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        go(); idle(2);

        // Randomized traffic.
        ar_phase = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if (k % 150 == 0) ar_phase = $urandom_range(0, 1);
            r  = ($urandom_range(0, 199) == 0);
            sp = ($urandom_range(0, 59) == 0);
            lv = ($urandom_range(0, 9) == 0);
            ps = ($urandom_range(0, 11) == 0);
            st = ($urandom_range(0, 3) == 0);
            te = ($urandom_range(0, 9) < 6);
            // Keep pause and start apart while idle, where their ordering has no meaning.
            if (!m_busy && ps && st) ps = 1'b0;
            cyc(r, lv, $urandom_range(0, 15), st, ps, sp, te, ar_phase);
        end

        idle(1);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
